// File: rtl/pmod_jstk_responder.sv
// PmodJSTK emulator: SPI mode-0 slave serving X/Y/button frames, decoding LED byte.
// Define JSTK_FRAME_ERR_EN to add FRAME_ERR pulse and ERR_CNT counter outputs.
module pmod_jstk_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BYTES = 5,
  parameter logic [5:0] CMD_PREFIX  = 6'b100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X_POS,
  input  logic [9:0] Y_POS,
  input  logic [2:0] BTN,
  output logic [1:0] LED_CMD,
  output logic       FRAME_DONE
`ifdef JSTK_FRAME_ERR_EN
  ,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT
`endif
);

  localparam int NBITS = 8 * FRAME_BYTES;
  localparam int CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NBITS);
  localparam logic [CW-1:0] CNT_CMD = CW'(7);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACTIVE  = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES:0]   flush;
  logic                   ss_d;
  logic                   sclk_d;
  logic [1:0]             state;
  logic [CW-1:0]          bit_cnt;
  logic [39:0]            tx_shift;
  logic [7:0]             rx_shift;
  logic                   cmd_chk;
  logic                   pend_vld;
  logic [1:0]             pend_led;

  logic ss_s, sclk_s, mosi_s;
  logic armed, first;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [39:0] snap;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Events are held off until the sync chains hold real pin samples.
  assign armed = flush[SYNC_STAGES];
  assign first = flush[SYNC_STAGES-1] & ~flush[SYNC_STAGES];

  assign ss_fall   = armed & ss_d & ~ss_s;
  assign ss_rise   = armed & ~ss_d & ss_s;
  assign sclk_rise = armed & ~sclk_d & sclk_s;
  assign sclk_fall = armed & sclk_d & ~sclk_s;

  assign snap = {X_POS[7:0], 6'b0, X_POS[9:8],
                 Y_POS[7:0], 6'b0, Y_POS[9:8],
                 5'b0, BTN};

  assign MISO = (state == ACTIVE) & tx_shift[39];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ss_sync    <= '1;
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      flush      <= '0;
      ss_d       <= 1'b1;
      sclk_d     <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      cmd_chk    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_led   <= 2'b00;
      LED_CMD    <= 2'b00;
      FRAME_DONE <= 1'b0;
    end else begin
      ss_sync    <= {ss_sync[SYNC_STAGES-2:0], SS};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      flush      <= {flush[SYNC_STAGES-1:0], 1'b1};
      ss_d       <= ss_s;
      sclk_d     <= sclk_s;
      FRAME_DONE <= 1'b0;
      cmd_chk    <= 1'b0;

      if (cmd_chk) begin
        pend_vld <= (rx_shift[7:2] == CMD_PREFIX);
        pend_led <= rx_shift[1:0];
      end

      case (state)
        IDLE: begin
          if (first && !ss_s) begin
            state <= WAIT_HI;
          end else if (ss_fall) begin
            state    <= ACTIVE;
            tx_shift <= snap;
            bit_cnt  <= '0;
            pend_vld <= 1'b0;
          end
        end
        ACTIVE: begin
          // SS rise takes priority over any SCLK edge seen in the same cycle.
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == CNT_MAX) begin
              FRAME_DONE <= 1'b1;
              if (pend_vld) LED_CMD <= pend_led;
            end
          end else if (sclk_rise && bit_cnt != CNT_MAX) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + CW'(1);
            if (bit_cnt == CNT_CMD) cmd_chk <= 1'b1;
            if (bit_cnt == CNT_MAX - CW'(1)) state <= WAIT_HI;
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[38:0], 1'b0};
          end
        end
        WAIT_HI: begin
          if (ss_s) begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (bit_cnt == CNT_MAX) begin
              FRAME_DONE <= 1'b1;
              if (pend_vld) LED_CMD <= pend_led;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JSTK_FRAME_ERR_EN
  logic err_ev;

  assign err_ev = (state == ACTIVE && ss_rise && bit_cnt != CNT_MAX) ||
                  (armed && ss_s && ss_d && (sclk_rise || sclk_fall));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= 8'd0;
    end else begin
      FRAME_ERR <= err_ev;
      if (err_ev && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Directed bench for pmod_jstk_responder: 1 MHz SPI master model, 100 MHz CLK.
module tb_pmod_jstk_responder;

  logic       CLK;
  logic       RESET;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic [9:0] X_POS;
  logic [9:0] Y_POS;
  logic [2:0] BTN;
  logic [1:0] LED_CMD;
  logic       FRAME_DONE;
`ifdef JSTK_FRAME_ERR_EN
  logic       FRAME_ERR;
  logic [7:0] ERR_CNT;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  pmod_jstk_responder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SS         (SS),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .X_POS      (X_POS),
    .Y_POS      (Y_POS),
    .BTN        (BTN),
    .LED_CMD    (LED_CMD),
    .FRAME_DONE (FRAME_DONE)
`ifdef JSTK_FRAME_ERR_EN
    ,
    .FRAME_ERR  (FRAME_ERR),
    .ERR_CNT    (ERR_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) done_cnt++;
`ifdef JSTK_FRAME_ERR_EN
    if (FRAME_ERR === 1'b1) err_cnt++;
`endif
  end

  // Mode-0 master: MOSI set while SCLK low, MISO read just before each rise.
  task automatic spi_frame(input int nbits, input logic [47:0] mo,
                           output logic [47:0] mi, input int chg_bit,
                           input logic [9:0] chg_x, input int rst_bit);
    mi = '0;
    SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[47-i];
      #500;
      mi[47-i] = MISO;
      SCLK = 1'b1;
      #500;
      SCLK = 1'b0;
      if (i + 1 == chg_bit) X_POS = chg_x;
      if (i + 1 == rst_bit) begin
        RESET = 1'b1;
        #50;
        RESET = 1'b0;
      end
    end
    MOSI = 1'b0;
    #500;
    SS = 1'b1;
    #400;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    SS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    X_POS = 10'h2A5;
    Y_POS = 10'h13C;
    BTN = 3'b101;
    #103;
    RESET = 1'b0;
    #200;
    checks++;
    if (MISO !== 1'b0) begin
      failures++;
      $display("FAIL reset_miso got=%b exp=0", MISO);
    end
    checks++;
    if (LED_CMD !== 2'b00) begin
      failures++;
      $display("FAIL reset_led got=%b exp=00", LED_CMD);
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL reset_done got=%0d exp=0", done_cnt);
    end
  endtask

  task automatic test_basic;
    logic [47:0] mi;
    logic [39:0] exp_bits;
    int d0;
    exp_bits = 40'hA5_02_3C_01_05;
    d0 = done_cnt;
    spi_frame(40, {8'h83, 40'h0}, mi, 0, 10'h0, 0);
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (mi[47-8*b -: 8] !== exp_bits[39-8*b -: 8]) begin
        failures++;
        $display("FAIL basic_byte%0d got=%h exp=%h", b,
                 mi[47-8*b -: 8], exp_bits[39-8*b -: 8]);
      end
    end
    checks++;
    if (LED_CMD !== 2'b11) begin
      failures++;
      $display("FAIL basic_led got=%b exp=11", LED_CMD);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL basic_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_snapshot;
    logic [47:0] mi;
    int d0;
    X_POS = 10'h3FF;
    d0 = done_cnt;
    spi_frame(40, 48'h0, mi, 4, 10'h000, 0);
    checks++;
    if (mi[47:40] !== 8'hFF) begin
      failures++;
      $display("FAIL snap_byte0 got=%h exp=ff", mi[47:40]);
    end
    checks++;
    if (mi[39:32] !== 8'h03) begin
      failures++;
      $display("FAIL snap_byte1 got=%h exp=03", mi[39:32]);
    end
    checks++;
    if (LED_CMD !== 2'b11) begin
      failures++;
      $display("FAIL snap_led got=%b exp=11", LED_CMD);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL snap_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_bad_prefix;
    logic [47:0] mi;
    int d0;
    X_POS = 10'h2A5;
    d0 = done_cnt;
    spi_frame(40, {8'h43, 40'h0}, mi, 0, 10'h0, 0);
    checks++;
    if (LED_CMD !== 2'b11) begin
      failures++;
      $display("FAIL badpfx_led got=%b exp=11", LED_CMD);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL badpfx_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_short;
    logic [47:0] mi;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(20, {8'h81, 40'h0}, mi, 0, 10'h0, 0);
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL short_done got=%0d exp=0", done_cnt - d0);
    end
    checks++;
    if (LED_CMD !== 2'b11) begin
      failures++;
      $display("FAIL short_led got=%b exp=11", LED_CMD);
    end
`ifdef JSTK_FRAME_ERR_EN
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++;
      $display("FAIL short_err_pulse got=%0d exp=1", err_cnt - e0);
    end
    checks++;
    if (ERR_CNT !== 8'd1) begin
      failures++;
      $display("FAIL short_err_cnt got=%0d exp=1", ERR_CNT);
    end
`endif
  endtask

  task automatic test_long;
    logic [47:0] mi;
    int d0;
    d0 = done_cnt;
    spi_frame(48, {8'h82, 40'h0}, mi, 0, 10'h0, 0);
    checks++;
    if (mi[47:8] !== 40'hA5_02_3C_01_05) begin
      failures++;
      $display("FAIL long_frame got=%h exp=a5023c0105", mi[47:8]);
    end
    checks++;
    if (mi[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL long_tail got=%h exp=00", mi[7:0]);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL long_done got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if (LED_CMD !== 2'b10) begin
      failures++;
      $display("FAIL long_led got=%b exp=10", LED_CMD);
    end
  endtask

  task automatic test_reset_mid;
    logic [47:0] mi;
    int d0;
    d0 = done_cnt;
    spi_frame(40, {8'h83, 40'h0}, mi, 0, 10'h0, 12);
    checks++;
    if (LED_CMD !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_led got=%b exp=00", LED_CMD);
    end
    checks++;
    if (mi[35:8] !== 28'h0) begin
      failures++;
      $display("FAIL rstmid_miso got=%h exp=0000000", mi[35:8]);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL rstmid_done got=%0d exp=0", done_cnt - d0);
    end
    d0 = done_cnt;
    spi_frame(40, {8'h83, 40'h0}, mi, 0, 10'h0, 0);
    checks++;
    if (mi[47:8] !== 40'hA5_02_3C_01_05) begin
      failures++;
      $display("FAIL rstmid_next_frame got=%h exp=a5023c0105", mi[47:8]);
    end
    checks++;
    if (LED_CMD !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_next_led got=%b exp=11", LED_CMD);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL rstmid_next_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_snapshot;
    test_bad_prefix;
    test_short;
    test_long;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
